// File: rtl/cpu_mem_pkg.sv
// Shared encodings for the instruction/data memory port arbiter.
// Pure declarations: no latency, no flow control.
package cpu_mem_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic OWNER_IF = 1'b0;
  localparam logic OWNER_D  = 1'b1;

  // Wide enough for MEM_LAT-1 with MEM_LAT up to 15.
  localparam int CNT_W = 4;
  typedef logic [CNT_W-1:0] cnt_t;

  function automatic cnt_t lat_preload(input int unsigned lat);
    return cnt_t'(lat - 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory side bundle of the arbiter; slave is the arbiter view.
// No latency of its own; requesters hold req until their ack.
interface mem_port_arbiter_if
  import cpu_mem_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
);

  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_ack;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_ack;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic          busy;
  logic          owner;

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_rdata, if_ack, d_rdata, d_ack,
    input  mem_en, mem_we, mem_addr, mem_wdata, busy, owner
  );

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_rdata, if_ack, d_rdata, d_ack,
    output mem_en, mem_we, mem_addr, mem_wdata, busy, owner
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; grant is combinational, last_grant flops on update.
// No backpressure: a grant is only recorded when upd_en_i is high.
module rr_arb2
  import cpu_mem_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic if_req_i,
  input  logic d_req_i,
  input  logic upd_en_i,
  output logic gnt_valid_o,
  output logic gnt_sel_o
);

  logic last_q;
  logic last_d;

  always_comb begin
    gnt_valid_o = if_req_i | d_req_i;
    gnt_sel_o   = OWNER_IF;
    if (if_req_i && d_req_i) begin
      gnt_sel_o = ~last_q;
    end else if (d_req_i) begin
      gnt_sel_o = OWNER_D;
    end

    last_d = last_q;
    if (upd_en_i && gnt_valid_o) begin
      last_d = gnt_sel_o;
    end
  end

  // Starting from data makes the first contention after reset go to fetch.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_q <= OWNER_D;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch and data requesters; ack comes MEM_LAT+2 cycles after grant.
// No backpressure: requesters hold req until their one-cycle ack; inputs are ignored between grant and IDLE.
module mem_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 2
) (
  input logic               CLK,
  input logic               RST,
  mem_port_arbiter_if.slave bus
);

  localparam cnt_t LAT_INIT = lat_preload(MEM_LAT);

  typedef struct packed {
    logic          owner;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } txn_t;

  state_t        state_q, state_d;
  cnt_t          cnt_q, cnt_d;
  txn_t          txn_q, txn_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;

  logic gnt_valid;
  logic gnt_sel;
  logic in_idle;

  assign in_idle = (state_q == S_IDLE);

  rr_arb2 u_arb (
    .clk_i      (CLK),
    .rst_i      (RST),
    .if_req_i   (bus.if_req),
    .d_req_i    (bus.d_req),
    .upd_en_i   (in_idle),
    .gnt_valid_o(gnt_valid),
    .gnt_sel_o  (gnt_sel)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    txn_d      = txn_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;

    case (state_q)
      S_IDLE: begin
        if (gnt_valid) begin
          txn_d.owner = gnt_sel;
          // A fetch can never write, whatever the data port is presenting.
          txn_d.we    = (gnt_sel == OWNER_D) & bus.d_we;
          txn_d.addr  = (gnt_sel == OWNER_D) ? bus.d_addr : bus.if_addr;
          txn_d.wdata = bus.d_wdata;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = LAT_INIT;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          if (!txn_q.we) begin
            if (txn_q.owner == OWNER_IF) begin
              if_rdata_d = bus.mem_rdata;
            end else begin
              d_rdata_d = bus.mem_rdata;
            end
          end
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      txn_q      <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      txn_q      <= txn_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  // Memory-side fields hold the latched transaction; only mem_en qualifies them.
  assign bus.mem_en    = (state_q == S_ISSUE);
  assign bus.mem_we    = txn_q.we;
  assign bus.mem_addr  = txn_q.addr;
  assign bus.mem_wdata = txn_q.wdata;

  assign bus.if_ack   = (state_q == S_RESP) && (txn_q.owner == OWNER_IF);
  assign bus.d_ack    = (state_q == S_RESP) && (txn_q.owner == OWNER_D);
  assign bus.if_rdata = if_rdata_q;
  assign bus.d_rdata  = d_rdata_q;
  assign bus.busy     = !in_idle;
  assign bus.owner    = txn_q.owner;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: directed requests push expected issues/acks, a negedge monitor pops and compares.
// Side instances with MEM_LAT 1 and 5 check single-read latency and data.
module tb_mem_port_arbiter;

  localparam int MEM_LAT = 2;

  logic clk;
  logic rst;
  logic rst_x;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   lanes_done = 0;

  typedef struct {
    logic        who;
    int          cyc;
    logic [31:0] ifr;
    logic [31:0] dr;
  } ack_t;

  typedef struct {
    int          cyc;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
  } iss_t;

  ack_t ackq[$];
  iss_t issq[$];

  logic [31:0] mem [logic [31:0]];
  int          rem = 0;
  logic [31:0] maddr = '0;

  mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

  mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(MEM_LAT)) u_dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc = cyc + 1;

  // Memory drives valid data only in the MEM_LAT-th cycle after mem_en, garbage otherwise.
  always @(negedge clk) begin
    logic [31:0] v;
    v = 32'hDEAD_0BAD;
    if (rst) begin
      rem = 0;
    end else begin
      if (rem > 0) begin
        rem = rem - 1;
        if (rem == 0) v = mem.exists(maddr) ? mem[maddr] : 32'hBAD0_0000;
      end
      if (bus.mem_en) begin
        rem   = MEM_LAT;
        maddr = bus.mem_addr;
        if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
      end
    end
    bus.mem_rdata = v;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic exp_ack(input logic who, input int c, input logic [31:0] ifr, input logic [31:0] dr);
    ackq.push_back(ack_t'{who, c, ifr, dr});
  endtask

  task automatic exp_iss(input int c, input logic we, input logic [31:0] a, input logic [31:0] wd);
    issq.push_back(iss_t'{c, we, a, wd});
  endtask

  task automatic monitor_step();
    ack_t a;
    iss_t s;
    if (bus.if_ack || bus.d_ack) begin
      if (ackq.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_ack: got if_ack=%0b d_ack=%0b at cycle %0d, required none",
                 bus.if_ack, bus.d_ack, cyc);
      end else begin
        a = ackq.pop_front();
        chk("single_ack", 32'(bus.if_ack & bus.d_ack), 32'd0);
        chk("ack_who", 32'(bus.d_ack), 32'(a.who));
        chk("ack_cycle", cyc, a.cyc);
        chk("ack_owner", 32'(bus.owner), 32'(a.who));
        chk("if_rdata", bus.if_rdata, a.ifr);
        chk("d_rdata", bus.d_rdata, a.dr);
      end
    end
    if (bus.mem_en) begin
      if (issq.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_issue: got mem_en=1 at cycle %0d, required 0", cyc);
      end else begin
        s = issq.pop_front();
        chk("issue_cycle", cyc, s.cyc);
        chk("mem_we", 32'(bus.mem_we), 32'(s.we));
        chk("mem_addr", bus.mem_addr, s.addr);
        if (s.we) chk("mem_wdata", bus.mem_wdata, s.wd);
      end
    end
  endtask

  task automatic wait_ack(input logic who);
    logic seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = who ? bus.d_ack : bus.if_ack;
    end
    if (!seen) begin
      n_cmp++;
      n_err++;
      $display("FAIL ack_timeout: got no %s ack in 40 cycles, required one", who ? "data" : "fetch");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] a);
    bus.if_req  = 1'b1;
    bus.if_addr = a;
    wait_ack(1'b0);
    bus.if_req = 1'b0;
  endtask

  task automatic data(input logic we, input logic [31:0] a, input logic [31:0] wd);
    bus.d_req   = 1'b1;
    bus.d_we    = we;
    bus.d_addr  = a;
    bus.d_wdata = wd;
    wait_ack(1'b1);
    bus.d_req = 1'b0;
  endtask

  task automatic check_zero(input string p);
    chk({p, "_busy"}, 32'(bus.busy), 32'd0);
    chk({p, "_mem_en"}, 32'(bus.mem_en), 32'd0);
    chk({p, "_mem_we"}, 32'(bus.mem_we), 32'd0);
    chk({p, "_if_ack"}, 32'(bus.if_ack), 32'd0);
    chk({p, "_d_ack"}, 32'(bus.d_ack), 32'd0);
    chk({p, "_owner"}, 32'(bus.owner), 32'd0);
    chk({p, "_mem_addr"}, bus.mem_addr, 32'd0);
    chk({p, "_mem_wdata"}, bus.mem_wdata, 32'd0);
    chk({p, "_if_rdata"}, bus.if_rdata, 32'd0);
    chk({p, "_d_rdata"}, bus.d_rdata, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #50000;
    n_err++;
    $display("FAIL watchdog: bench still running at %0t, required completion", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    logic [5:0] bpat;

    bus.if_req  = 1'b0;
    bus.if_addr = '0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
    rst   = 1'b0;
    rst_x = 1'b0;

    mem[32'h4]   = 32'h2001_0005;
    mem[32'h8]   = 32'h1111_0008;
    mem[32'h10]  = 32'h2222_0010;
    mem[32'h100] = 32'h3333_0100;
    mem[32'h104] = 32'h4444_0104;
    mem[32'h200] = 32'h5555_0200;
    mem[32'h204] = 32'h6666_0204;

    #1;
    rst   = 1'b1;
    rst_x = 1'b1;
    @(posedge clk);
    #1;
    check_zero("reset");
    repeat (2) @(posedge clk);
    #1;
    rst   = 1'b0;
    rst_x = 1'b0;

    fork
      forever begin
        @(negedge clk);
        if (!rst) monitor_step();
      end
    join_none

    // Fetch-only read; a stale d_we=1 must not leak into the fetch.
    bus.d_we = 1'b1;
    t = cyc;
    bpat = 6'b011110;
    exp_iss(t + 1, 1'b0, 32'h4, 32'h0);
    exp_ack(1'b0, t + 4, 32'h2001_0005, 32'h0);
    fork
      fetch(32'h4);
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        chk("busy_seq", 32'(bus.busy), 32'(bpat[i]));
      end
    join

    // Contention straight after reset goes to fetch first.
    do_reset();
    t = cyc;
    exp_iss(t + 1, 1'b0, 32'h8, 32'h0);
    exp_ack(1'b0, t + 4, 32'h1111_0008, 32'h0);
    exp_iss(t + 6, 1'b0, 32'h10, 32'h0);
    exp_ack(1'b1, t + 9, 32'h1111_0008, 32'h2222_0010);
    fork
      fetch(32'h8);
      data(1'b0, 32'h10, 32'h0);
    join

    // Both requesters continuously busy: IF, D, IF, D, five cycles apart.
    t = cyc;
    exp_iss(t + 1, 1'b0, 32'h100, 32'h0);
    exp_ack(1'b0, t + 4, 32'h3333_0100, 32'h2222_0010);
    exp_iss(t + 6, 1'b0, 32'h200, 32'h0);
    exp_ack(1'b1, t + 9, 32'h3333_0100, 32'h5555_0200);
    exp_iss(t + 11, 1'b0, 32'h104, 32'h0);
    exp_ack(1'b0, t + 14, 32'h4444_0104, 32'h5555_0200);
    exp_iss(t + 16, 1'b0, 32'h204, 32'h0);
    exp_ack(1'b1, t + 19, 32'h4444_0104, 32'h6666_0204);
    fork
      begin
        fetch(32'h100);
        fetch(32'h104);
      end
      begin
        data(1'b0, 32'h200, 32'h0);
        data(1'b0, 32'h204, 32'h0);
      end
    join

    // Write leaves both rdata registers alone; read-back proves it reached memory.
    t = cyc;
    exp_iss(t + 1, 1'b1, 32'h40, 32'hDEAD_BEEF);
    exp_ack(1'b1, t + 4, 32'h4444_0104, 32'h6666_0204);
    data(1'b1, 32'h40, 32'hDEAD_BEEF);
    t = cyc;
    exp_iss(t + 1, 1'b0, 32'h40, 32'h0);
    exp_ack(1'b1, t + 4, 32'h4444_0104, 32'hDEAD_BEEF);
    data(1'b0, 32'h40, 32'h0);

    // Reset in the first WAIT cycle drops the fetch without an ack.
    t = cyc;
    exp_iss(t + 1, 1'b0, 32'h4, 32'h0);
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h4;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    bus.if_req = 1'b0;
    #1;
    check_zero("midrst");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("if_rdata_after_drop", bus.if_rdata, 32'h0);
    t = cyc;
    exp_iss(t + 1, 1'b0, 32'h8, 32'h0);
    exp_ack(1'b0, t + 4, 32'h1111_0008, 32'h0);
    fetch(32'h8);

    repeat (3) @(posedge clk);
    #1;
    chk("acks_pending", ackq.size(), 32'd0);
    chk("issues_pending", issq.size(), 32'd0);
    chk("lat_lanes_done", lanes_done, 32'd2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  for (genvar k = 0; k < 2; k++) begin : g_lat
    localparam int          LAT     = (k == 0) ? 1 : 5;
    localparam int          EXP_LAT = (k == 0) ? 3 : 7;
    localparam logic [31:0] ADDR    = (k == 0) ? 32'h60 : 32'h64;
    localparam logic [31:0] EXP_D   = (k == 0) ? 32'h5A5A_0060 : 32'h5A5A_0064;

    mem_port_arbiter_if #(.AW(32), .DW(32)) xb ();

    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(LAT)) u_dut_x (
      .CLK(clk),
      .RST(rst_x),
      .bus(xb)
    );

    int          rem_x = 0;
    logic [31:0] addr_x = '0;
    int          exp_cyc_q[$];

    always @(negedge clk) begin
      logic [31:0] v;
      v = 32'hDEAD_0BAD;
      if (rem_x > 0) begin
        rem_x = rem_x - 1;
        if (rem_x == 0) v = 32'h5A5A_0000 | {16'h0, addr_x[15:0]};
      end
      if (xb.mem_en) begin
        rem_x  = LAT;
        addr_x = xb.mem_addr;
      end
      xb.mem_rdata = v;
      if (xb.if_ack) begin
        if (exp_cyc_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL lat%0d_unexpected_ack: got if_ack=1 at cycle %0d, required none", LAT, cyc);
        end else begin
          chk("lat_ack_cycle", cyc, exp_cyc_q.pop_front());
          chk("lat_rdata", xb.if_rdata, EXP_D);
          lanes_done++;
        end
      end
    end

    initial begin
      xb.if_req  = 1'b0;
      xb.if_addr = '0;
      xb.d_req   = 1'b0;
      xb.d_we    = 1'b0;
      xb.d_addr  = '0;
      xb.d_wdata = '0;
      wait (rst_x == 1'b1);
      wait (rst_x == 1'b0);
      @(posedge clk);
      #1;
      exp_cyc_q.push_back(cyc + EXP_LAT);
      xb.if_req  = 1'b1;
      xb.if_addr = ADDR;
      for (int i = 0; i < 20 && !xb.if_ack; i++) @(negedge clk);
      @(posedge clk);
      #1;
      xb.if_req = 1'b0;
    end
  end

endmodule
